// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - timing defaults, bit-period helpers and FSM state types for the UART echo path
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ = 50_000_000;
  localparam int unsigned DEF_BAUD     = 115_200;

  function automatic int unsigned bit_cyc(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic int unsigned half_cyc(input int unsigned clk_freq, input int unsigned baud);
    return bit_cyc(clk_freq, baud) / 2;
  endfunction

  // RX_BREAK holds off re-arming after a bad stop bit until the line returns high
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 byte receiver: input synchronizer, mid-bit sampling FSM, byte/valid/frame-error outputs
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned BAUD     = DEF_BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err
);

  localparam int unsigned BIT_CYC  = bit_cyc(CLK_FREQ, BAUD);
  localparam int unsigned HALF_CYC = half_cyc(CLK_FREQ, BAUD);
  localparam int          CW       = $clog2(BIT_CYC);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);

  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d, data_q, data_d;
  logic          valid_q, valid_d, ferr_q, ferr_d;
  logic          sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= i_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: if (cnt_q == HALF_LAST) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = sync2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == BIT_LAST) begin
        cnt_d   = '0;
        shift_d = {sync2_q, shift_q[7:1]};
        idx_d   = idx_q + 1'b1;
        if (idx_q == 3'd7) state_d = RX_STOP;
      end
      RX_STOP: if (cnt_q == BIT_LAST) begin
        cnt_d = '0;
        if (sync2_q) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          state_d = RX_IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = RX_BREAK;
        end
      end
      RX_BREAK: begin
        cnt_d = '0;
        if (sync2_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;

endmodule

// File: rtl/uart_loopback.sv
// rtl/uart_loopback.sv - UART echo: received bytes queue in a small FIFO and are retransmitted unchanged
module uart_loopback
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned BAUD       = DEF_BAUD,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TX_BAUD    = BAUD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_uart_rx,
  output logic       o_uart_tx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_frame_err,
  output logic       o_overflow,
  output logic       o_tx_busy
);

  localparam int unsigned TX_BIT_CYC = bit_cyc(CLK_FREQ, TX_BAUD);
  localparam int          TCW        = $clog2(TX_BIT_CYC);
  localparam logic [TCW-1:0] TX_BIT_LAST = TCW'(TX_BIT_CYC - 1);
  localparam int          AW         = $clog2(FIFO_DEPTH);
  localparam int          AW1        = AW + 1;
  localparam logic [AW:0] FIFO_FULL  = AW1'(FIFO_DEPTH);

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx        (i_uart_rx),
    .o_data      (o_rx_data),
    .o_valid     (o_rx_valid),
    .o_frame_err (o_frame_err)
  );

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          overflow_q, full, empty, pop, accept;

  assign full   = (count_q == FIFO_FULL);
  assign empty  = (count_q == '0);
  // a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign accept = o_rx_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= o_rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + AW1'(accept) - AW1'(pop);
      if (o_rx_valid && !accept) overflow_q <= 1'b1;
    end
  end

  tx_state_t      tx_state_q, tx_state_d;
  logic [TCW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]     tx_idx_q, tx_idx_d;
  logic [7:0]     tx_shift_q, tx_shift_d;
  logic           tx_q, busy_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    pop        = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (!empty) begin
          pop        = 1'b1;
          tx_shift_d = mem_q[rd_ptr_q];
          tx_state_d = TX_START;
        end
      end
      TX_START: if (tx_cnt_q == TX_BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_idx_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_cnt_q == TX_BIT_LAST) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        tx_idx_d   = tx_idx_q + 1'b1;
        if (tx_idx_q == 3'd7) tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_cnt_q == TX_BIT_LAST) begin
        tx_cnt_d = '0;
        if (!empty) begin
          pop        = 1'b1;
          tx_shift_d = mem_q[rd_ptr_q];
          tx_state_d = TX_START;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
    endcase
  end

  // line level and busy are registered from the state, trailing it by one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= (tx_state_q == TX_START) ? 1'b0 :
                    (tx_state_q == TX_DATA)  ? tx_shift_q[0] : 1'b1;
      busy_q     <= (tx_state_q != TX_IDLE);
    end
  end

  assign o_uart_tx  = tx_q;
  assign o_tx_busy  = busy_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_uart_loopback.sv
// tb/tb_uart_loopback.sv - directed self-checking bench for uart_loopback (default instance plus a slow-tx, 2-deep instance)
module tb_uart_loopback;

  localparam int BC_M    = 434;
  localparam int BC_S_RX = 43;
  localparam int BC_S_TX = 100;

  logic clk = 1'b0;
  logic rst_n;
  logic rx_m, tx_m, rxv_m, fe_m, ov_m, busy_m;
  logic rx_s, tx_s, rxv_s, fe_s, ov_s, busy_s;
  logic [7:0] rxd_m, rxd_s;

  int n_checks = 0;
  int n_errors = 0;

  always #10 clk = ~clk;

  uart_loopback dut (
    .clk(clk), .rst_n(rst_n), .i_uart_rx(rx_m), .o_uart_tx(tx_m),
    .o_rx_data(rxd_m), .o_rx_valid(rxv_m), .o_frame_err(fe_m),
    .o_overflow(ov_m), .o_tx_busy(busy_m)
  );

  uart_loopback #(.CLK_FREQ(5_000_000), .BAUD(115_200), .FIFO_DEPTH(2), .TX_BAUD(50_000)) dut_ovf (
    .clk(clk), .rst_n(rst_n), .i_uart_rx(rx_s), .o_uart_tx(tx_s),
    .o_rx_data(rxd_s), .o_rx_valid(rxv_s), .o_frame_err(fe_s),
    .o_overflow(ov_s), .o_tx_busy(busy_s)
  );

  int unsigned cyc = 0, valid_cnt = 0, ferr_cnt = 0, busy_rise = 0, busy_fall = 0;
  int unsigned valid_cyc = 0, txstart_cyc = 0;
  logic tx_p = 1'b1, busy_p = 1'b0;

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    tx_p   <= tx_m;
    busy_p <= busy_m;
    if (rxv_m) begin
      valid_cnt <= valid_cnt + 1;
      valid_cyc <= cyc;
    end
    if (fe_m) ferr_cnt <= ferr_cnt + 1;
    if (busy_m && !busy_p) busy_rise <= busy_rise + 1;
    if (!busy_m && busy_p) busy_fall <= busy_fall + 1;
    if (tx_p && !tx_m && !busy_p) txstart_cyc <= cyc;
  end

  logic [7:0] q_m[$];
  logic [7:0] q_s[$];

  initial begin : mon_main
    logic [7:0] b;
    forever begin
      @(negedge tx_m);
      repeat (BC_M / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BC_M) @(negedge clk);
        b[i] = tx_m;
      end
      repeat (BC_M) @(negedge clk);
      if (tx_m) q_m.push_back(b);
    end
  end

  initial begin : mon_slow
    logic [7:0] b;
    forever begin
      @(negedge tx_s);
      repeat (BC_S_TX / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BC_S_TX) @(negedge clk);
        b[i] = tx_s;
      end
      repeat (BC_S_TX) @(negedge clk);
      if (tx_s) q_s.push_back(b);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input bit slow);
    if (slow) rx_s = v;
    else rx_m = v;
    repeat (slow ? BC_S_RX : BC_M) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok, input bit slow);
    drive_bit(1'b0, slow);
    for (int i = 0; i < 8; i++) drive_bit(b[i], slow);
    drive_bit(stop_ok, slow);
  endtask

  task automatic wait_q(input bit slow, input int n, input int limit);
    for (int i = 0; i < limit; i++) begin
      if ((slow ? q_s.size() : q_m.size()) >= n) break;
      @(negedge clk);
    end
    repeat (300) @(negedge clk);
  endtask

  initial begin
    int unsigned b_v, b_f, b_br, b_bf;
    int qi, lat;
    logic [7:0] b2b [4];
    logic [7:0] ovf_in [6];
    logic [7:0] ovf_exp [5];
    b2b     = '{8'h00, 8'hFF, 8'h55, 8'hA5};
    ovf_in  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    ovf_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66};

    rst_n = 1'b0;
    rx_m  = 1'b1;
    rx_s  = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_tx", tx_m, 1);
    check("rst_busy", busy_m, 0);
    check("rst_valid", rxv_m, 0);
    check("rst_ferr", fe_m, 0);
    check("rst_ovf", ov_m, 0);
    check("rst_data", rxd_m, 8'h00);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_tx", tx_m, 1);
    check("idle_busy", busy_m, 0);
    check("idle_q", q_m.size(), 0);

    // single echo of 0x3D
    b_v = valid_cnt;
    send(8'h3D, 1'b1, 1'b0);
    check("single_valid_cnt", valid_cnt - b_v, 1);
    check("single_rx_data", rxd_m, 8'h3D);
    wait_q(1'b0, 1, 6000);
    check("single_q_size", q_m.size(), 1);
    check("single_echo", q_m[0], 8'h3D);
    lat = int'(txstart_cyc) - int'(valid_cyc);
    check("echo_latency", (lat >= 2 && lat <= 4) ? 3 : lat, 3);
    qi = 1;

    // four frames with no gaps
    b_v = valid_cnt; b_br = busy_rise; b_bf = busy_fall;
    for (int k = 0; k < 4; k++) send(b2b[k], 1'b1, 1'b0);
    wait_q(1'b0, qi + 4, 8000);
    check("b2b_q_size", q_m.size(), qi + 4);
    for (int k = 0; k < 4; k++) check($sformatf("b2b_echo%0d", k), q_m[qi + k], b2b[k]);
    check("b2b_busy_rise", busy_rise - b_br, 1);
    check("b2b_busy_fall", busy_fall - b_bf, 1);
    check("b2b_valid_cnt", valid_cnt - b_v, 4);
    check("b2b_ovf", ov_m, 0);
    qi += 4;

    // stop bit forced low, then a good frame
    b_v = valid_cnt; b_f = ferr_cnt; b_br = busy_rise;
    send(8'h3D, 1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    check("ferr_cnt", ferr_cnt - b_f, 1);
    check("ferr_no_valid", valid_cnt - b_v, 0);
    check("ferr_no_tx", busy_rise - b_br, 0);
    send(8'h12, 1'b1, 1'b0);
    wait_q(1'b0, qi + 1, 6000);
    check("ferr_q_size", q_m.size(), qi + 1);
    check("after_ferr_echo", q_m[qi], 8'h12);
    check("after_ferr_rx_data", rxd_m, 8'h12);
    qi += 1;

    // 100-cycle glitch on the line
    b_v = valid_cnt; b_f = ferr_cnt;
    rx_m = 1'b0;
    repeat (100) @(negedge clk);
    rx_m = 1'b1;
    repeat (600) @(negedge clk);
    check("glitch_valid", valid_cnt - b_v, 0);
    check("glitch_ferr", ferr_cnt - b_f, 0);
    check("glitch_busy", busy_m, 0);

    // reset while data bit 1 of 0xA5 is on the line
    send(8'hA5, 1'b1, 1'b0);
    repeat (BC_M * 2) @(negedge clk);
    check("pre_rst_bit1", tx_m, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_tx", tx_m, 1);
    check("mid_rst_busy", busy_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    b_br = busy_rise;
    repeat (4500) @(negedge clk);
    check("post_rst_no_tx", busy_rise - b_br, 0);
    check("post_rst_line", tx_m, 1);

    // slow-tx, 2-deep instance: 6 back-to-back frames, the fifth is dropped
    for (int k = 0; k < 6; k++) send(ovf_in[k], 1'b1, 1'b1);
    wait_q(1'b1, 5, 6000);
    repeat (1200) @(negedge clk);
    check("ovf_q_size", q_s.size(), 5);
    for (int k = 0; k < 5; k++) check($sformatf("ovf_echo%0d", k), q_s[k], ovf_exp[k]);
    check("ovf_sticky", ov_s, 1);
    check("main_no_ovf", ov_m, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
